// File: rtl/inst_queue_scheduler_if.sv
// ---------------------------------------------------------------------------
// inst_queue_scheduler_if
// Groups the RPi-side queue interface, the task_manager handshake and the
// status outputs of inst_queue_scheduler into one bundle.
//   master : the RPi / task_manager side (drives push, flush, inst_valid, idle)
//   slave  : the scheduler itself
// Signals:
//   push_valid/push_inst/push_ready : enqueue handshake
//   flush                           : discard queued (not in-flight) entries
//   RPi_inst/execute_task           : instruction and issue pulse to task_manager
//   inst_valid/idle                 : task_manager feedback
//   busy/queue_count/*_count        : status for the RPi
// ---------------------------------------------------------------------------
interface inst_queue_scheduler_if #(
  parameter int INST_W = 80,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              push_valid;
  logic [INST_W-1:0] push_inst;
  logic              push_ready;
  logic              flush;
  logic [INST_W-1:0] RPi_inst;
  logic              execute_task;
  logic              inst_valid;
  logic              idle;
  logic              busy;
  logic [CNT_W-1:0]  queue_count;
  logic [15:0]       done_count;
  logic [15:0]       reject_count;
  logic [15:0]       noop_count;

  modport master (
    output push_valid, push_inst, flush, inst_valid, idle,
    input  push_ready, RPi_inst, execute_task, busy, queue_count,
           done_count, reject_count, noop_count
  );

  modport slave (
    input  push_valid, push_inst, flush, inst_valid, idle,
    output push_ready, RPi_inst, execute_task, busy, queue_count,
           done_count, reject_count, noop_count
  );
endinterface

// File: rtl/inst_queue_scheduler.sv
// ---------------------------------------------------------------------------
// inst_queue_scheduler
// Buffers RPi instructions in a FIFO and hands them one at a time to
// task_manager. An instruction is issued (one-cycle execute_task) only when
// task_manager reports idle and inst_valid; the task is then tracked until
// idle falls and rises again. Invalid instructions are dropped; instructions
// that never make idle fall within START_TIMEOUT cycles are retired as no-ops.
// Ports:
//   clk   : system clock, all logic on posedge
//   reset : synchronous, active-high
//   bus   : inst_queue_scheduler_if.slave (queue, task_manager, status)
// ---------------------------------------------------------------------------
module inst_queue_scheduler #(
  parameter int INST_W        = 80,
  parameter int DEPTH         = 8,
  parameter int START_TIMEOUT = 8
) (
  input logic                   clk,
  input logic                   reset,
  inst_queue_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(START_TIMEOUT);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE
  } state_e;

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  state_e            state_q, state_d;
  logic [INST_W-1:0] rpi_inst_q, rpi_inst_d;
  logic              exec_q, exec_d;
  logic              busy_q;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [15:0]       done_q, done_d;
  logic [15:0]       reject_q, reject_d;
  logic [15:0]       noop_q, noop_d;

  logic              push_ready;
  logic              push;
  logic              pop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Ready comes from the registered count only, so a pop in the same cycle
  // never makes room for that cycle's push.
  assign push_ready = ~reset & (count_q < FULL_CNT) & ~bus.flush;
  assign push       = bus.push_valid & push_ready;

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and the pointers/count (which are reset) decide validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.push_inst;
    end
  end

  // FIFO bookkeeping. Flush wins over push and pop (pop is already blocked by
  // flush in the FSM, push by push_ready).
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) count_d = count_q + CNT_W'(1);
      if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    rpi_inst_d = rpi_inst_q;
    exec_d     = 1'b0;
    timer_d    = timer_q;
    done_d     = done_q;
    reject_d   = reject_q;
    noop_d     = noop_q;
    pop        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && bus.idle && !bus.flush) begin
          pop        = 1'b1;
          rpi_inst_d = mem_q[rd_ptr_q];
          state_d    = S_CHECK;
        end
      end
      // RPi_inst has been stable for a cycle, so task_manager's combinational
      // inst_valid is now meaningful.
      S_CHECK: begin
        if (!bus.inst_valid) begin
          reject_d = sat_inc(reject_q);
          state_d  = S_IDLE;
        end else if (bus.idle) begin
          exec_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_START;
      end
      // A task that never drops idle is a no-op; retire it after the window.
      S_WAIT_START: begin
        if (!bus.idle) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TMR_LAST) begin
          noop_d  = sat_inc(noop_q);
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      // task_manager bounds the job length, so no timeout here.
      S_WAIT_DONE: begin
        if (bus.idle) begin
          done_d  = sat_inc(done_q);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      rpi_inst_q <= '0;
      exec_q     <= 1'b0;
      busy_q     <= 1'b0;
      timer_q    <= '0;
      done_q     <= '0;
      reject_q   <= '0;
      noop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      rpi_inst_q <= rpi_inst_d;
      exec_q     <= exec_d;
      busy_q     <= (state_d != S_IDLE);
      timer_q    <= timer_d;
      done_q     <= done_d;
      reject_q   <= reject_d;
      noop_q     <= noop_d;
    end
  end

  assign bus.push_ready   = push_ready;
  assign bus.RPi_inst     = rpi_inst_q;
  assign bus.execute_task = exec_q;
  assign bus.busy         = busy_q;
  assign bus.queue_count  = count_q;
  assign bus.done_count   = done_q;
  assign bus.reject_count = reject_q;
  assign bus.noop_count   = noop_q;

endmodule

// File: tb/tb_inst_queue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_inst_queue_scheduler
// Directed bench for inst_queue_scheduler. A transaction-level model (a queue
// of instructions plus the life cycle of the one job in flight) predicts every
// output and is compared against the DUT on each falling edge; literal
// expectations pin the model in each scenario. task_manager is emulated by
// driving idle directly and deriving inst_valid from the task code
// (code 8'h00 is invalid).
// ---------------------------------------------------------------------------
module tb_inst_queue_scheduler;
  localparam int INST_W        = 80;
  localparam int DEPTH         = 8;
  localparam int START_TIMEOUT = 8;

  // Life cycle of the job currently owned by the scheduler.
  localparam int J_NONE     = 0;  // nothing owned
  localparam int J_VETTING  = 1;  // presented, awaiting validity/idle
  localparam int J_FIRED    = 2;  // issue pulse on the wire
  localparam int J_STARTING = 3;  // waiting for task_manager to leave idle
  localparam int J_RUNNING  = 4;  // waiting for task_manager to return to idle

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   chk_en = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   exec_pulses = 0;

  inst_queue_scheduler_if #(.INST_W(INST_W), .DEPTH(DEPTH)) bus ();

  inst_queue_scheduler #(
    .INST_W(INST_W), .DEPTH(DEPTH), .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.inst_valid = (bus.RPi_inst[79:72] != 8'h00);

  task automatic check(input string name, input logic [INST_W-1:0] act,
                       input logic [INST_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  // ---------------- model ----------------
  logic [INST_W-1:0] m_q[$];
  logic [INST_W-1:0] m_inst = '0;
  int m_job = J_NONE;
  int m_waited = 0;
  int m_done = 0;
  int m_rej = 0;
  int m_noop = 0;
  bit m_exec = 1'b0;

  always @(posedge clk) begin
    bit take;
    bit keep;
    if (reset) begin
      m_q.delete();
      m_inst   = '0;
      m_job    = J_NONE;
      m_waited = 0;
      m_done   = 0;
      m_rej    = 0;
      m_noop   = 0;
      m_exec   = 1'b0;
    end else begin
      take   = (m_job == J_NONE) && (m_q.size() > 0) && bus.idle && !bus.flush;
      keep   = bus.push_valid && (m_q.size() < DEPTH) && !bus.flush;
      m_exec = 1'b0;
      case (m_job)
        J_NONE: if (take) begin
          m_inst = m_q[0];
          m_job  = J_VETTING;
        end
        J_VETTING: begin
          if (m_inst[79:72] == 8'h00) begin
            m_rej++;
            m_job = J_NONE;
          end else if (bus.idle) begin
            m_exec = 1'b1;
            m_job  = J_FIRED;
          end
        end
        J_FIRED: begin
          m_waited = 0;
          m_job    = J_STARTING;
        end
        J_STARTING: begin
          if (!bus.idle) begin
            m_job = J_RUNNING;
          end else begin
            m_waited++;
            if (m_waited == START_TIMEOUT) begin
              m_noop++;
              m_job = J_NONE;
            end
          end
        end
        J_RUNNING: if (bus.idle) begin
          m_done++;
          m_job = J_NONE;
        end
        default: m_job = J_NONE;
      endcase
      if (bus.flush) begin
        m_q.delete();
      end else begin
        if (take) void'(m_q.pop_front());
        if (keep) m_q.push_back(bus.push_inst);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("push_ready", INST_W'(bus.push_ready),
            INST_W'(!reset && (m_q.size() < DEPTH) && !bus.flush));
      check("queue_count", INST_W'(bus.queue_count), INST_W'(m_q.size()));
      check("busy", INST_W'(bus.busy), INST_W'(m_job != J_NONE));
      check("execute_task", INST_W'(bus.execute_task), INST_W'(m_exec));
      check("RPi_inst", bus.RPi_inst, m_inst);
      check("done_count", INST_W'(bus.done_count), INST_W'(sat16(m_done)));
      check("reject_count", INST_W'(bus.reject_count), INST_W'(sat16(m_rej)));
      check("noop_count", INST_W'(bus.noop_count), INST_W'(sat16(m_noop)));
      if (bus.execute_task === 1'b1) exec_pulses++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [INST_W-1:0] v);
    bus.push_valid = 1'b1;
    bus.push_inst  = v;
    step();
    bus.push_valid = 1'b0;
  endtask

  // Waits (bounded) for the issue pulse; returns cycles waited.
  task automatic wait_exec(input string name, output int n);
    n = 0;
    while (bus.execute_task !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check(name, INST_W'(bus.execute_task), INST_W'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    bus.push_valid = 1'b0;
    bus.push_inst  = '0;
    bus.flush      = 1'b0;
    bus.idle       = 1'b0;

    // Reset held two cycles.
    reset = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    #1;
    check("reset push_ready low", INST_W'(bus.push_ready), INST_W'(0));
    step();
    check("reset queue_count", INST_W'(bus.queue_count), INST_W'(0));
    check("reset busy", INST_W'(bus.busy), INST_W'(0));
    check("reset execute_task", INST_W'(bus.execute_task), INST_W'(0));
    check("reset RPi_inst", bus.RPi_inst, INST_W'(0));
    reset = 1'b0;
    step();
    check("push_ready after reset", INST_W'(bus.push_ready), INST_W'(1));

    // Fill with task_manager busy: nine offers, eight stored.
    bus.idle = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.push_valid = 1'b1;
      bus.push_inst  = {8'(8'h10 + i), 72'(i)};
      step();
    end
    bus.push_valid = 1'b0;
    check("fill queue_count", INST_W'(bus.queue_count), INST_W'(8));
    check("fill push_ready", INST_W'(bus.push_ready), INST_W'(0));
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush empties", INST_W'(bus.queue_count), INST_W'(0));

    // Valid task: latency counted from the cycle push_valid is raised.
    bus.idle = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_inst  = {INST_W{1'b1}};
    step();
    bus.push_valid = 1'b0;
    lat = 1;
    while (bus.execute_task !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check("issue latency", INST_W'(lat), INST_W'(3));
    check("RPi_inst all ones", bus.RPi_inst, {INST_W{1'b1}});
    step();
    check("execute one cycle", INST_W'(bus.execute_task), INST_W'(0));
    bus.idle = 1'b0;
    step(20);
    bus.idle = 1'b1;
    step(2);
    check("valid done_count", INST_W'(bus.done_count), INST_W'(1));
    check("valid busy cleared", INST_W'(bus.busy), INST_W'(0));
    check("valid queue empty", INST_W'(bus.queue_count), INST_W'(0));

    // Invalid entry followed by a no-op entry.
    bus.idle = 1'b0;
    push_one({8'h00, 72'hA0A0});
    push_one({8'h12, 72'hB0B0});
    base = exec_pulses;
    bus.idle = 1'b1;
    step(30);
    check("reject_count", INST_W'(bus.reject_count), INST_W'(1));
    check("noop_count", INST_W'(bus.noop_count), INST_W'(1));
    check("single issue pulse", INST_W'(exec_pulses - base), INST_W'(1));
    check("next entry popped", bus.RPi_inst, {8'h12, 72'hB0B0});
    check("noop busy cleared", INST_W'(bus.busy), INST_W'(0));

    // Flush plus push while a task is in flight with three entries queued.
    push_one({8'h21, 72'h5});
    wait_exec("flush scenario issue", lat);
    step();
    bus.idle = 1'b0;
    step(2);
    for (int i = 0; i < 3; i++) push_one({8'h30, 72'(i)});
    check("three queued", INST_W'(bus.queue_count), INST_W'(3));
    bus.flush      = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_inst  = {8'h33, 72'h77};
    step();
    bus.flush      = 1'b0;
    bus.push_valid = 1'b0;
    check("flush count zero", INST_W'(bus.queue_count), INST_W'(0));
    check("in-flight survives flush", INST_W'(bus.busy), INST_W'(1));
    step(5);
    bus.idle = 1'b1;
    step(3);
    check("in-flight done_count", INST_W'(bus.done_count), INST_W'(2));
    check("flush busy cleared", INST_W'(bus.busy), INST_W'(0));

    // Reset in the middle of a running task with entries queued.
    push_one({8'h44, 72'h9});
    wait_exec("reset scenario issue", lat);
    step();
    bus.idle = 1'b0;
    step(2);
    push_one({8'h45, 72'h1});
    push_one({8'h46, 72'h2});
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset busy", INST_W'(bus.busy), INST_W'(0));
    check("midreset queue", INST_W'(bus.queue_count), INST_W'(0));
    check("midreset done_count", INST_W'(bus.done_count), INST_W'(0));
    check("midreset RPi_inst", bus.RPi_inst, INST_W'(0));
    step(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
